dmem_responder: RTL and testbench
=================================

# dmem_responder

Word-organised data-memory target for the rv32 memory-access stage. It accepts load and store requests over a valid/ready request channel and returns results over a valid/ready response channel after a configurable number of wait states. It has one request outstanding at a time, per-byte write strobes, and flags bad addresses. It replaces the zero-latency dmem model so the pipeline's stall and hazard logic can be exercised against a realistic memory.

## Interface
Parameters:
- DEPTH, 1024: memory size in 32-bit words; must be a power of two.
- WAIT, 2: wait states between request acceptance and the array access; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  responder can accept a request.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data; byte lane k is bits 8k+7:8k.
- i_req_be  in  4  store byte enables; ignored for loads.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  requester accepts the response.
- o_rsp_rdata  out  32  load data; 0 for stores and for errors.
- o_rsp_err  out  1  request was rejected.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- **IDLE**
  - o_req_ready = 1.
  - A handshake occurs when i_req_valid and o_req_ready are both high at a rising edge.
  - On a handshake, latch we, addr, wdata and be.
  - If WAIT = 0, perform the access and go to RESP. Otherwise load the counter with WAIT-1 and go to WAIT.
- **WAIT**
  - o_req_ready = 0.
  - The counter decrements each cycle.
  - When the counter reaches 0, perform the access on that edge and go to RESP.
- **RESP**
  - o_rsp_valid = 1, with o_rsp_rdata and o_rsp_err held stable.
  - The state holds until i_rsp_ready = 1 at a rising edge, then returns to IDLE.
  - A new request cannot be accepted on the same edge the response completes.
- **Access**
  - Word index = addr[log2(DEPTH)+1:2].
  - A store writes only the byte lanes whose be bit is 1. be = 4'b0000 completes as a no-op with err = 0.
  - A load registers the full word into o_rsp_rdata.
- **Error** (only with DMEM_RSP_ERR_EN): a request is in error if addr[1:0] != 0 or addr[31:2] >= DEPTH.
  - An errored request writes nothing, returns rdata = 0 and err = 1, and takes the same latency as a good request.
- Request inputs are sampled only at the handshake edge; changes to them afterwards have no effect.
- Memory contents are not cleared by reset.

## Timing
- **Reset values:**
  - State = IDLE.
  - o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0.
  - o_req_ready = 0 while rst is low, and 1 from the first cycle after rst goes high (o_req_ready = rst & (state == IDLE)).
- **Latency:** for a handshake at edge N, o_rsp_valid is high from edge N+WAIT+1.
  - WAIT = 0 gives a response the cycle after acceptance.
- **Throughput:** with i_rsp_ready held at 1, a request is accepted every WAIT+2 cycles.
- **Reset mid-operation:** asserting rst in WAIT or RESP aborts the transaction.
  - A store still in WAIT is not committed.
  - A store already in RESP remains committed.
  - The response is discarded.
- Response backpressure of any length is legal. Outputs must not change while o_rsp_valid = 1 and i_rsp_ready = 0.

## Configuration
- DMEM_RSP_ERR_EN defined: alignment and range checks are active, and o_rsp_err is driven as described in Operation.
- DMEM_RSP_ERR_EN undefined:
  - addr[1:0] is ignored.
  - The word index wraps modulo DEPTH (addr[31:2] & (DEPTH-1)).
  - o_rsp_err is tied to 0.
  - Latency is unchanged.

## Test plan
- **Store/load round trip:** WAIT=2. Store addr 0x10, data 0xDEADBEEF, be 4'hF, then load 0x10. Required: each o_rsp_valid arrives 3 cycles after acceptance; the load returns 0xDEADBEEF with err = 0.
- **Byte strobes:** store 0x11223344 to 0x20, then store 0xAABBCCDD with be 4'b0101, then load 0x20. Required: rdata = 0x11BB33DD.
- **Backpressure:** hold i_rsp_ready = 0 for 5 cycles in RESP while i_req_valid = 1. Required: o_req_ready stays 0 and rdata/err stay stable. The next request is accepted no earlier than the cycle after the response handshake.
- **Errors (macro on, DEPTH=1024):** load 0x2 → err = 1, rdata = 0. Store to 0x1000 → err = 1, and a later load of 0x0 is unchanged.
- **Wrap (macro off):** store 0x5A5A5A5A to 0x1000, then load 0x0. Required: returns 0x5A5A5A5A with err = 0.
- **Mid-operation reset:** WAIT=3. Store 0xCAFEF00D to 0x40, which already holds 0x0, and assert rst during WAIT. Required: outputs reset immediately, and a load of 0x40 after reset returns 0x0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory with wait states and valid/ready channels; DMEM_RSP_ERR_EN enables address checks
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q, cnt, cnt_nx;
  logic        hs, acc, a_we, a_err;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic [AW-1:0] a_idx;
  assign o_req_ready = rst & (state == S_IDLE);
  assign o_rsp_valid = state == S_RESP;
  assign hs      = i_req_valid & o_req_ready;
  assign a_we    = state == S_IDLE ? i_req_we    : we_q;
  assign a_addr  = state == S_IDLE ? i_req_addr  : addr_q;
  assign a_wdata = state == S_IDLE ? i_req_wdata : wdata_q;
  assign a_be    = state == S_IDLE ? i_req_be    : be_q;
  assign a_idx   = a_addr[AW+1:2];
`ifdef DMEM_RSP_ERR_EN
  assign a_err = (|a_addr[1:0]) | ({2'b00, a_addr[31:2]} >= 32'(DEPTH));
`else
  logic addr_unused;
  assign addr_unused = ^{a_addr[31:AW+2], a_addr[1:0]};
  assign a_err = 1'b0;
`endif
  // next state, wait counter and access strobe; with WAIT=0 the access happens on the handshake edge
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    acc      = 1'b0;
    if (state == S_IDLE && hs) begin
      acc      = WAIT == 0;
      state_nx = WAIT == 0 ? S_RESP : S_WAIT;
      cnt_nx   = WAIT == 0 ? 4'd0 : 4'(WAIT - 1);
    end else if (state == S_WAIT) begin
      acc      = cnt == 4'd0;
      state_nx = cnt == 4'd0 ? S_RESP : S_WAIT;
      cnt_nx   = cnt - 4'd1;
    end else if (state == S_RESP && i_rsp_ready) begin
      state_nx = S_IDLE;
    end
  end
  // state, request latch and response registers; response fields change only on an access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (hs) begin
        we_q    <= i_req_we;
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
        be_q    <= i_req_be;
      end
      if (acc) begin
        o_rsp_rdata <= (a_we | a_err) ? '0 : mem[a_idx];
        o_rsp_err   <= a_err;
      end
    end
  end
  // byte-strobed array write; contents survive reset
  always_ff @(posedge clk) begin
    if (acc & a_we & ~a_err)
      for (int i = 0; i < 4; i++)
        if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder at WAIT=2 (main) and WAIT=3 (mid-operation reset)
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_a, rst_b, sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        a_req_ready, a_rsp_valid, a_rsp_err, b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] a_rsp_rdata, b_rsp_rdata;
  logic        rdy, rv, er;
  logic [31:0] rd;
  logic [32:0] sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT(2)) u_a (
    .clk(clk), .rst(rst_a), .i_req_valid(req_valid), .o_req_ready(a_req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(a_rsp_rdata), .o_rsp_err(a_rsp_err)
  );
  dmem_responder #(.DEPTH(1024), .WAIT(3)) u_b (
    .clk(clk), .rst(rst_b), .i_req_valid(req_valid), .o_req_ready(b_req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(b_rsp_rdata), .o_rsp_err(b_rsp_err)
  );

  assign rdy = sel ? b_req_ready : a_req_ready;
  assign rv  = sel ? b_rsp_valid : a_rsp_valid;
  assign rd  = sel ? b_rsp_rdata : a_rsp_rdata;
  assign er  = sel ? b_rsp_err   : a_rsp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e, input int bp);
    int lat;
    logic [32:0] e;
    sb.push_back({exp_e, exp_d});
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    check({tag, "/req_ready"}, 32'(rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = bp > 0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1;
    while (!rv && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), sel ? 32'd4 : 32'd3);
    e = sb.pop_front();
    check({tag, "/rdata"}, rd, e[31:0]);
    check({tag, "/err"}, 32'(er), 32'(e[32]));
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      check({tag, "/bp_req_ready"}, 32'(rdy), 32'd0);
      check({tag, "/bp_valid"}, 32'(rv), 32'd1);
      check({tag, "/bp_rdata"}, rd, e[31:0]);
      check({tag, "/bp_err"}, 32'(er), 32'(e[32]));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, "/done_valid"}, 32'(rv), 32'd0);
    check({tag, "/done_ready"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/req_ready", 32'(a_req_ready), 32'd0);
    check("rst/rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst/rdata", a_rsp_rdata, 32'd0);
    check("rst/err", 32'(a_rsp_err), 32'd0);
    rst_a = 1'b1;
    xact("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    xact("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    xact("st20", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
    xact("st20_be5", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 5);
    xact("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 5);
    xact("st20_be0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 0);
    xact("ld20_again", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 0);
    xact("st0", 1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, 1'b0, 0);
`ifdef DMEM_RSP_ERR_EN
    xact("ld2_misalign", 1'b0, 32'h2, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    xact("st1000_range", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    xact("ld0_intact", 1'b0, 32'h0, 32'h0, 4'h0, 32'h01020304, 1'b0, 0);
`else
    xact("st1000_wrap", 1'b1, 32'h1000, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, 0);
    xact("ld0_wrap", 1'b0, 32'h0, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, 0);
    xact("ld3_lowbits", 1'b0, 32'h3, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, 0);
`endif
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b1; sel = 1'b1;
    xact("b_st40_zero", 1'b1, 32'h40, 32'h0, 4'hF, 32'h0, 1'b0, 0);
    xact("b_st44", 1'b1, 32'h44, 32'h12345678, 4'hF, 32'h0, 1'b0, 0);
    xact("b_ld44", 1'b0, 32'h44, 32'h0, 4'h0, 32'h12345678, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst/in_wait", 32'(b_req_ready), 32'd0);
    rst_b = 1'b0;
    #1;
    check("midrst/rsp_valid", 32'(b_rsp_valid), 32'd0);
    check("midrst/rdata", b_rsp_rdata, 32'd0);
    check("midrst/err", 32'(b_rsp_err), 32'd0);
    check("midrst/req_ready", 32'(b_req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    xact("b_ld40_uncommitted", 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0, 0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
